// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID read checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_ID,
        ST_LAT_ID,
        ST_REQ_TS,
        ST_LAT_TS,
        ST_FIN
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1453155989;

    // Bits needed to count 0..max_count inclusive.
    function automatic int sysid_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/avm_single_read.sv
// Single-word Avalon-MM read engine: issues one read per go pulse, rides out
// waitrequest, waits the fixed slave latency and reports data/valid/timeout.
// valid and data are combinational so the caller can capture on the same
// edge and launch the next read with no gap.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        addr,
    output logic        avm_read,
    output logic        avm_address,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        accepted,
    output logic        valid,
    output logic        timed_out,
    output logic [31:0] data
);

    localparam int                 STALL_W    = sysid_cnt_width(TIMEOUT_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         LAT_LOAD   = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]         lat_cnt;
    logic               lat_active;

    assign accepted  = avm_read & ~avm_waitrequest;
    // The last permitted stall cycle ends the read instead of extending it.
    assign timed_out = avm_read & avm_waitrequest & (stall_cnt == STALL_LAST);
    assign valid     = (READ_LATENCY == 0) ? accepted : (lat_active & (lat_cnt == 2'd0));
    assign data      = avm_readdata;

    // Read strobe, stall counting and latency countdown for one transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
            lat_active  <= 1'b0;
        end else if (go) begin
            avm_read    <= 1'b1;
            avm_address <= addr;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
            lat_active  <= 1'b0;
        end else if (avm_read) begin
            if (!avm_waitrequest) begin
                avm_read <= 1'b0;
                if (READ_LATENCY > 0) begin
                    lat_active <= 1'b1;
                    lat_cnt    <= LAT_LOAD;
                end
            end else if (timed_out) begin
                avm_read <= 1'b0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else if (lat_active) begin
            if (lat_cnt == 2'd0) begin
                lat_active <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysid_read_checker.sv
// Boot-time integrity check: reads the system ID then the build timestamp
// from the sysid slave and compares both against build-time constants.
module sysid_read_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    sysid_state_t state;

    logic        eng_go;
    logic        eng_addr;
    logic        eng_accepted;
    logic        eng_valid;
    logic        eng_timeout;
    logic [31:0] eng_data;
    logic        can_start;
    logic        in_id_phase;

    assign can_start   = (state == ST_IDLE) || (state == ST_FIN);
    assign in_id_phase = (state == ST_REQ_ID) || (state == ST_LAT_ID);

    // Launch the ID read on an accepted start, and the timestamp read on the
    // very edge the ID word arrives.
    always_comb begin
        eng_go   = 1'b0;
        eng_addr = SYSID_ADDR_ID;
        if (can_start && start) begin
            eng_go   = 1'b1;
            eng_addr = SYSID_ADDR_ID;
        end else if (in_id_phase && eng_valid) begin
            eng_go   = 1'b1;
            eng_addr = SYSID_ADDR_TS;
        end
    end

    avm_single_read #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read (
        .clock           (clock),
        .reset_n         (reset_n),
        .go              (eng_go),
        .addr            (eng_addr),
        .avm_read        (avm_read),
        .avm_address     (avm_address),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .accepted        (eng_accepted),
        .valid           (eng_valid),
        .timed_out       (eng_timeout),
        .data            (eng_data)
    );

    // Check sequencer with registered status and captured words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            captured_id <= '0;
            captured_ts <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        state   <= ST_REQ_ID;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                ST_REQ_ID, ST_LAT_ID: begin
                    if (eng_valid) begin
                        captured_id <= eng_data;
                        state       <= ST_REQ_TS;
                    end else if (eng_accepted) begin
                        state <= ST_LAT_ID;
                    end else if (eng_timeout) begin
                        state   <= ST_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_REQ_TS, ST_LAT_TS: begin
                    if (eng_valid) begin
                        captured_ts <= eng_data;
                        id_ok       <= (captured_id == EXPECTED_ID);
                        ts_ok       <= (eng_data == EXPECTED_TIMESTAMP);
                        pass        <= (captured_id == EXPECTED_ID) && (eng_data == EXPECTED_TIMESTAMP);
                        state       <= ST_FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (eng_accepted) begin
                        state <= ST_LAT_TS;
                    end else if (eng_timeout) begin
                        id_ok   <= (captured_id == EXPECTED_ID);
                        state   <= ST_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
